// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control path: opcodes, ALUOp,
// mux selects, FSM states and the bundled control word.
package mips_ctrl_pkg;

  localparam logic [3:0] OP_RTYPE = 4'b0000;
  localparam logic [3:0] OP_ADDI  = 4'b0001;
  localparam logic [3:0] OP_LW    = 4'b0010;
  localparam logic [3:0] OP_SW    = 4'b0011;
  localparam logic [3:0] OP_BEQ   = 4'b0100;
  localparam logic [3:0] OP_SLTI  = 4'b0101;
  localparam logic [3:0] OP_J     = 4'b0110;

  localparam logic [1:0] ALUOP_ADD   = 2'b11;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b00;
  localparam logic [1:0] ALUOP_SLT   = 2'b10;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_ONE   = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_BROFF = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_RESET  = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_RTEXE  = 4'd7,
    S_RTWB   = 4'd8,
    S_ADDIEX = 4'd9,
    S_SLTIEX = 4'd10,
    S_IWB    = 4'd11,
    S_BRANCH = 4'd12,
    S_JUMP   = 4'd13
  } state_e;

  typedef struct packed {
    logic       pcWrite;
    logic       pcWriteCond;
    logic       iorD;
    logic       memRead;
    logic       memWrite;
    logic       irWrite;
    logic       memToReg;
    logic       regDst;
    logic       regWrite;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic [1:0] pcSource;
    logic [1:0] aluOp;
  } ctrl_t;

endpackage

// File: rtl/mips_ctrl_outdec.sv
// Pure state-to-control-word decode. FETCH raises IRWrite/PCWrite here
// unconditionally; the FSM qualifies them with MemReady.
module mips_ctrl_outdec
  import mips_ctrl_pkg::*;
(
  input  state_e state_i,
  output ctrl_t  ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    case (state_i)
      S_FETCH: begin
        ctrl_o.memRead  = 1'b1;
        ctrl_o.aluSrcB  = SRCB_ONE;
        ctrl_o.aluOp    = ALUOP_ADD;
        ctrl_o.pcSource = PCSRC_ALU;
        ctrl_o.irWrite  = 1'b1;
        ctrl_o.pcWrite  = 1'b1;
      end
      S_DECODE: begin
        ctrl_o.aluSrcB = SRCB_BROFF;
        ctrl_o.aluOp   = ALUOP_ADD;
      end
      S_MEMADR, S_ADDIEX: begin
        ctrl_o.aluSrcA = 1'b1;
        ctrl_o.aluSrcB = SRCB_IMM;
        ctrl_o.aluOp   = ALUOP_ADD;
      end
      S_MEMRD: begin
        ctrl_o.memRead = 1'b1;
        ctrl_o.iorD    = 1'b1;
      end
      S_MEMWB: begin
        ctrl_o.regWrite = 1'b1;
        ctrl_o.memToReg = 1'b1;
      end
      S_MEMWR: begin
        ctrl_o.memWrite = 1'b1;
        ctrl_o.iorD     = 1'b1;
      end
      S_RTEXE: begin
        ctrl_o.aluSrcA = 1'b1;
        ctrl_o.aluSrcB = SRCB_B;
        ctrl_o.aluOp   = ALUOP_RTYPE;
      end
      S_RTWB: begin
        ctrl_o.regWrite = 1'b1;
        ctrl_o.regDst   = 1'b1;
      end
      S_SLTIEX: begin
        ctrl_o.aluSrcA = 1'b1;
        ctrl_o.aluSrcB = SRCB_IMM;
        ctrl_o.aluOp   = ALUOP_SLT;
      end
      S_IWB: ctrl_o.regWrite = 1'b1;
      S_BRANCH: begin
        ctrl_o.aluSrcA     = 1'b1;
        ctrl_o.aluSrcB     = SRCB_B;
        ctrl_o.aluOp       = ALUOP_SUB;
        ctrl_o.pcWriteCond = 1'b1;
        ctrl_o.pcSource    = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        ctrl_o.pcWrite  = 1'b1;
        ctrl_o.pcSource = PCSRC_JUMP;
      end
      default: ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/mips_main_control_fsm.sv
// Multi-cycle MIPS main control: state register, next-state sequencing with
// memory-ready stalls, and MemReady gating of the fetch-time register loads.
module mips_main_control_fsm
  import mips_ctrl_pkg::*;
#(
  parameter int OPCODE_W = 4,
  parameter int ST_W     = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [OPCODE_W-1:0] Opcode,
  input  logic                MemReady,
  output logic                PCWrite,
  output logic                PCWriteCond,
  output logic                IorD,
  output logic                MemRead,
  output logic                MemWrite,
  output logic                IRWrite,
  output logic                MemtoReg,
  output logic                RegDst,
  output logic                RegWrite,
  output logic                ALUSrcA,
  output logic [1:0]          ALUSrcB,
  output logic [1:0]          PCSource,
  output logic [1:0]          ALUOp,
  output logic [ST_W-1:0]     State
);

  state_e state_q, state_d;
  ctrl_t  ctrl;
  logic   fetchStall;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_RESET;
    else     state_q <= state_d;
  end

  // MEMADR re-decodes the opcode; the instruction register still holds it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RESET:  state_d = S_FETCH;
      S_FETCH:  if (MemReady) state_d = S_DECODE;
      S_DECODE: begin
        case (Opcode)
          OPCODE_W'(OP_RTYPE): state_d = S_RTEXE;
          OPCODE_W'(OP_LW),
          OPCODE_W'(OP_SW):    state_d = S_MEMADR;
          OPCODE_W'(OP_ADDI):  state_d = S_ADDIEX;
          OPCODE_W'(OP_SLTI):  state_d = S_SLTIEX;
          OPCODE_W'(OP_BEQ):   state_d = S_BRANCH;
          OPCODE_W'(OP_J):     state_d = S_JUMP;
          default:             state_d = S_FETCH;
        endcase
      end
      S_MEMADR: state_d = (Opcode == OPCODE_W'(OP_SW)) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (MemReady) state_d = S_MEMWB;
      S_MEMWR:  if (MemReady) state_d = S_FETCH;
      S_RTEXE:  state_d = S_RTWB;
      S_ADDIEX, S_SLTIEX: state_d = S_IWB;
      S_MEMWB, S_RTWB, S_IWB, S_BRANCH, S_JUMP: state_d = S_FETCH;
      default:  state_d = S_RESET;
    endcase
  end

  mips_ctrl_outdec u_outdec (
    .state_i (state_q),
    .ctrl_o  (ctrl)
  );

  assign fetchStall  = (state_q == S_FETCH) && !MemReady;
  assign PCWrite     = ctrl.pcWrite & ~fetchStall;
  assign IRWrite     = ctrl.irWrite & ~fetchStall;
  assign PCWriteCond = ctrl.pcWriteCond;
  assign IorD        = ctrl.iorD;
  assign MemRead     = ctrl.memRead;
  assign MemWrite    = ctrl.memWrite;
  assign MemtoReg    = ctrl.memToReg;
  assign RegDst      = ctrl.regDst;
  assign RegWrite    = ctrl.regWrite;
  assign ALUSrcA     = ctrl.aluSrcA;
  assign ALUSrcB     = ctrl.aluSrcB;
  assign PCSource    = ctrl.pcSource;
  assign ALUOp       = ctrl.aluOp;
  assign State       = ST_W'(state_q);

endmodule
